// File: rtl/sigmoid_rr_scheduler.sv
// sigmoid_rr_scheduler: round-robin sharing of one pipelined Q8.8 sigmoid engine among N requesters,
// with a latency-matched tag pipeline that routes each saturated result back to its requester.
module sigmoid_rr_scheduler #(
  parameter int N   = 4,
  parameter int LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N-1:0]         req_valid,
  input  logic [16*N-1:0]      req_x,
  output logic [N-1:0]         req_ready,
  output logic                 eng_valid,
  output logic [15:0]          eng_x,
  input  logic [15:0]          eng_y,
  output logic [N-1:0]         rsp_valid,
  output logic [15:0]          rsp_y,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [3:0]           inflight,
  output logic                 busy
);
  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  logic [IW-1:0]          r_ptr, r_grant_id, w_g;
  logic                   w_hit, r_eng_valid;
  logic [IW:0]            w_s;
  logic [15:0]            r_eng_x, r_rsp_y, w_sat;
  logic [N-1:0]           r_rsp_valid;
  logic [3:0]             r_inflight;
  logic [LAT-1:0]         r_tag_v;
  logic [LAT-1:0][IW-1:0] r_tag_id;
  // scan from the highest offset down so the lowest offset from r_ptr wins
  always_comb begin
    w_hit = 1'b0;
    w_g   = '0;
    w_s   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_s = {1'b0, r_ptr} + (IW+1)'(i);
      w_s = (w_s >= (IW+1)'(N)) ? w_s - (IW+1)'(N) : w_s;
      if (req_valid[w_s[IW-1:0]] && ena && !rst) begin
        w_hit = 1'b1;
        w_g   = w_s[IW-1:0];
      end
    end
  end
  assign w_sat = eng_y[15] ? 16'h0000 : (eng_y > 16'h0100) ? 16'h0100 : eng_y;
  // the tag pipe is fed from the eng_valid register so its last stage lines up with eng_y
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_grant_id  <= '0;
      r_eng_valid <= 1'b0;
      r_eng_x     <= '0;
      r_tag_v     <= '0;
      r_tag_id    <= '0;
      r_rsp_valid <= '0;
      r_rsp_y     <= '0;
      r_inflight  <= '0;
    end else begin
      r_ptr       <= w_hit ? ((w_g == IW'(N - 1)) ? '0 : w_g + 1'b1) : r_ptr;
      r_grant_id  <= w_hit ? w_g : r_grant_id;
      r_eng_valid <= w_hit;
      r_eng_x     <= w_hit ? req_x[{w_g, 4'b0} +: 16] : r_eng_x;
      r_tag_v[0]  <= r_eng_valid;
      r_tag_id[0] <= r_grant_id;
      for (int i = 1; i < LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      r_rsp_valid <= r_tag_v[LAT-1] ? ONE << r_tag_id[LAT-1] : '0;
      r_rsp_y     <= r_tag_v[LAT-1] ? w_sat : r_rsp_y;
      r_inflight  <= (w_hit && !(|r_rsp_valid)) ? r_inflight + 4'd1 :
                     (!w_hit && |r_rsp_valid) ? r_inflight - 4'd1 : r_inflight;
    end
  end
  assign req_ready = w_hit ? ONE << w_g : '0;
  assign eng_valid = r_eng_valid;
  assign eng_x     = r_eng_x;
  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign grant_id  = r_grant_id;
  assign inflight  = r_inflight;
  assign busy      = |r_inflight;
endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// tb_sigmoid_rr_scheduler: directed checks of three scheduler instances (LAT 1, 4, 2) driven in lockstep,
// each with a model engine returning its operand + 0x0080 exactly LAT cycles later.
module tb_sigmoid_rr_scheduler;
  localparam int N = 4;
  logic            clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_x = '0;
  logic [N-1:0]    rdy [3];
  logic            ev  [3];
  logic [15:0]     ex  [3];
  logic [15:0]     ey  [3];
  logic [N-1:0]    rv  [3];
  logic [15:0]     ry  [3];
  logic [1:0]      gid [3];
  logic [3:0]      inf [3];
  logic            bsy [3];
  logic [15:0]     xs [6] = '{16'h0100, 16'hFF00, 16'h0081, 16'h0080, 16'h007F, 16'h8000};
  logic [15:0]     ys [6] = '{16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h00FF, 16'h0000};
  int              total = 0, passes = 0, nrsp = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : (k == 1) ? 4 : 2;
    logic [15:0] xd [L];
    sigmoid_rr_scheduler #(.N(N), .LAT(L)) u_dut (
      .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_x(req_x),
      .req_ready(rdy[k]), .eng_valid(ev[k]), .eng_x(ex[k]), .eng_y(ey[k]),
      .rsp_valid(rv[k]), .rsp_y(ry[k]), .grant_id(gid[k]), .inflight(inf[k]), .busy(bsy[k])
    );
    always_ff @(posedge clk) begin
      xd[0] <= ex[k];
      for (int j = 1; j < L; j++) xd[j] <= xd[j-1];
    end
    assign ey[k] = xd[L-1] + 16'h0080;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
  endtask
  initial begin
    req_valid = 4'b1111;
    @(negedge clk); #1;
    chk("rst_ready", rdy[0], 0);
    chk("rst_eng_valid", ev[0], 0);
    chk("rst_eng_x", ex[0], 0);
    chk("rst_rsp_valid", rv[0], 0);
    chk("rst_rsp_y", ry[0], 0);
    chk("rst_grant_id", gid[0], 0);
    chk("rst_inflight", inf[0], 0);
    @(negedge clk); rst = 1'b0; req_valid = 4'b0001; #1;
    chk("single_ready", rdy[0], 4'b0001);
    @(negedge clk); req_valid = 4'b0000; #1;
    chk("single_eng_valid", ev[0], 1);
    chk("single_eng_x", ex[0], 16'h0000);
    chk("single_inflight", inf[0], 1);
    @(negedge clk); #1;
    chk("single_eng_valid_drop", ev[0], 0);
    chk("single_rsp_early", rv[0], 0);
    @(negedge clk); #1;
    chk("single_rsp_valid", rv[0], 4'b0001);
    chk("single_rsp_y", ry[0], 16'h0080);
    chk("single_busy", bsy[0], 1);
    @(negedge clk); #1;
    chk("single_rsp_pulse", rv[0], 0);
    chk("single_idle", inf[0], 0);
    chk("single_busy_low", bsy[0], 0);
    @(negedge clk); rst = 1'b1;
    req_x = {16'h0030, 16'h0020, 16'h0010, 16'h0000};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); rst = 1'b0; req_valid = (c < 8) ? 4'b1111 : 4'b0000; #1;
      if (c < 8) chk("rr_ready", rdy[0], 4'b0001 << (c % 4));
      if (c >= 1 && c < 9) chk("rr_grant_id", gid[0], (c - 1) % 4);
      if (c >= 3 && c < 11) begin
        chk("rr_rsp_valid", rv[0], 4'b0001 << ((c - 3) % 4));
        chk("rr_rsp_y", ry[0], 16'h0080 + 16'h0010 * ((c - 3) % 4));
      end
    end
    chk("rr_idle", inf[0], 0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); req_valid = (c < 10) ? 4'b0001 : 4'b0000; req_x[15:0] = 16'(c * 16); #1;
      if (c < 10) chk("b2b_ready", rdy[2], 4'b0001);
      if (c >= 4 && c < 10) chk("b2b_inflight", inf[2], 4);
      if (rv[2] != 0) begin
        nrsp++;
        chk("b2b_rsp_valid", rv[2], 4'b0001);
        chk("b2b_rsp_y", ry[2], (c - 4 >= 8) ? 16'h0100 : 16'h0080 + 16'((c - 4) * 16));
      end
    end
    chk("b2b_count", nrsp, 10);
    chk("b2b_idle", inf[2], 0);
    chk("b2b_busy", bsy[2], 0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); req_valid = (c < 6) ? 4'b0001 : 4'b0000;
      if (c < 6) req_x[15:0] = xs[c];
      #1;
      if (c >= 3 && c < 6) chk("sat_inflight", inf[0], 3);
      if (c >= 3) begin
        chk("sat_rsp_valid", rv[0], 4'b0001);
        chk("sat_rsp_y", ry[0], ys[c-3]);
      end
    end
    req_valid = 4'b0000;
    repeat (6) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); req_valid = 4'b1111; #1;
      chk("mf_ready", rdy[1], 4'b0010 << c);
    end
    @(negedge clk); req_valid = 4'b0000; rst = 1'b1; #1;
    chk("mf_inflight", inf[1], 3);
    @(negedge clk); rst = 1'b0; #1;
    chk("mf_inflight_clr", inf[1], 0);
    chk("mf_eng_valid_clr", ev[1], 0);
    chk("mf_grant_id_clr", gid[1], 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      chk("mf_no_rsp", rv[1], 0);
    end
    chk("mf_busy", bsy[1], 0);
    @(negedge clk); req_valid = 4'b0111; req_x[15:0] = 16'h0040; #1;
    chk("mf_next_grant", rdy[1], 4'b0001);
    @(negedge clk); req_valid = 4'b0110; ena = 1'b0; #1;
    chk("ena_ready_off", rdy[0], 0);
    @(negedge clk); #1;
    chk("ena_ready_off2", rdy[0], 0);
    chk("ena_busy", bsy[0], 1);
    @(negedge clk); #1;
    chk("ena_rsp_valid", rv[0], 4'b0001);
    chk("ena_rsp_y", ry[0], 16'h00C0);
    chk("ena_busy_last", bsy[0], 1);
    @(negedge clk); #1;
    chk("ena_rsp_pulse", rv[0], 0);
    chk("ena_busy_low", bsy[0], 0);
    chk("ena_ready_off3", rdy[0], 0);
    @(negedge clk); ena = 1'b1; #1;
    chk("ena_resume", rdy[0], 4'b0010);
    @(negedge clk); req_valid = 4'b0100; #1;
    chk("ena_next", rdy[0], 4'b0100);
    @(negedge clk); req_valid = 4'b0000;
    repeat (8) @(negedge clk);
    #1;
    chk("final_idle", inf[1], 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
